// File: rtl/except_commit.sv
// -----------------------------------------------------------------------------
// except_commit
//
// MEM-stage exception commit unit. Holds the instruction's exception vector,
// PC, delay-slot flag and data address in a stage register. It merges in
// pending hardware interrupts and selects the highest-priority cause. A
// detected exception or ERET produces a single registered commit. The pipeline
// flush is then held for FLUSH_CYCLES cycles, and new_pc_o is held stable
// while the flush is active.
//
// Optional feature: define EXCEPT_COMMIT_INT_SYNC_EN to pass hw_int_i through
// a SYNC_STAGES-deep synchroniser. When it is undefined, ip_hw_o mirrors
// hw_int_i combinationally.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   stall_i, flush_i       hold / squash of the stage register
//   in_valid_i             incoming instruction valid
//   excepttype_i           exception bit vector from decode
//   pc_i, delay_slot_i     instruction PC and branch-delay-slot flag
//   mem_addr_i             data address reported for AdEL/AdES
//   hw_int_i               raw hardware interrupt lines
//   cp0_status_i/cause_i/epc_i  current CP0 register values
//   exc_valid_o            one-cycle exception commit pulse
//   exc_code_o, exc_epc_o, exc_bd_o   ExcCode, EPC and Cause.BD to write
//   badvaddr_we_o, badvaddr_o         BadVAddr write
//   eret_o                 one-cycle ERET commit pulse
//   flush_o, new_pc_o      pipeline flush and redirect PC
//   ip_hw_o                interrupt lines feeding Cause.IP[7:2]
// -----------------------------------------------------------------------------
module except_commit #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] pc_i,
   input  logic        delay_slot_i,
   input  logic [31:0] mem_addr_i,
   input  logic [5:0]  hw_int_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   output logic        exc_valid_o,
   output logic [4:0]  exc_code_o,
   output logic [31:0] exc_epc_o,
   output logic        exc_bd_o,
   output logic        badvaddr_we_o,
   output logic [31:0] badvaddr_o,
   output logic        eret_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic [5:0]  ip_hw_o
);

   // Bit positions inside the decode exception vector.
   localparam int bit_int  = 0;
   localparam int bit_adel = 4;
   localparam int bit_ades = 5;
   localparam int bit_sys  = 8;
   localparam int bit_bp   = 9;
   localparam int bit_ri   = 10;
   localparam int bit_ov   = 12;
   localparam int bit_eret = 31;

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;

   logic               stg_valid;
   logic [31:0]        stg_type;
   logic [31:0]        stg_pc;
   logic               stg_bd;
   logic [31:0]        stg_addr;

   logic               int_pending;
   logic               c_int;
   logic               has_exc;
   logic               take;
   logic [4:0]         code_sel;
   logic               badv_sel;
   logic [31:0]        epc_val;
   logic [31:0]        badv_val;

   // Only a subset of the vector and CP0 bits is consumed here.
   logic               unused_bits;
   assign unused_bits = ^{stg_type, cp0_status_i[31:16], cp0_status_i[7:2],
                          cp0_cause_i[31:10], cp0_cause_i[7:0]};

   // ---------------------------------------------------------------- interrupts
`ifdef EXCEPT_COMMIT_INT_SYNC_EN
   logic [SYNC_STAGES-1:0][5:0] sync_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_reg <= '0;
      else         sync_reg <= {sync_reg[SYNC_STAGES-2:0], hw_int_i};
   end

   assign ip_hw_o = sync_reg[SYNC_STAGES-1];
`else
   assign ip_hw_o = hw_int_i;
`endif

   assign int_pending = cp0_status_i[0] & ~cp0_status_i[1] &
                        (|({ip_hw_o, cp0_cause_i[9:8]} & cp0_status_i[15:8]));

   // -------------------------------------------------------------- stage register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stg_valid <= 1'b0;
         stg_type  <= '0;
         stg_pc    <= '0;
         stg_bd    <= 1'b0;
         stg_addr  <= '0;
      end else if (flush_i || state == ST_FLUSH) begin
         stg_valid <= 1'b0;
      end else if (!stall_i) begin
         stg_valid <= in_valid_i;
         stg_type  <= excepttype_i;
         stg_pc    <= pc_i;
         stg_bd    <= delay_slot_i;
         stg_addr  <= mem_addr_i;
      end
   end

   // ------------------------------------------------------------ cause selection
   assign c_int    = int_pending | stg_type[bit_int];
   assign has_exc  = c_int | stg_type[bit_adel] | stg_type[bit_ri] | stg_type[bit_ov] |
                     stg_type[bit_sys] | stg_type[bit_bp] | stg_type[bit_ades];
   assign epc_val  = stg_bd ? (stg_pc - 32'd4) : stg_pc;
   // A misaligned PC is the faulting address (fetch side), otherwise the data address.
   assign badv_val = (stg_pc[1:0] != 2'b00) ? stg_pc : stg_addr;

   always_comb begin
      code_sel = 5'd0;
      badv_sel = 1'b0;
      if (c_int)                   code_sel = 5'd0;
      else if (stg_type[bit_adel]) begin code_sel = 5'd4; badv_sel = 1'b1; end
      else if (stg_type[bit_ri])   code_sel = 5'd10;
      else if (stg_type[bit_ov])   code_sel = 5'd12;
      else if (stg_type[bit_sys])  code_sel = 5'd8;
      else if (stg_type[bit_bp])   code_sel = 5'd9;
      else if (stg_type[bit_ades]) begin code_sel = 5'd5; badv_sel = 1'b1; end
   end

   // ------------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      take       = 1'b0;
      case (state)
         ST_IDLE: begin
            take = stg_valid & ~stall_i & ~flush_i & (has_exc | stg_type[bit_eret]);
            if (take) begin
               state_next = ST_FLUSH;
               cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         ST_FLUSH: begin
            if (cnt == '0) state_next = ST_IDLE;
            else           cnt_next   = cnt - CNT_W'(1);
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign flush_o = (state == ST_FLUSH);

   // -------------------------------------------------------------- commit outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_valid_o   <= 1'b0;
         exc_code_o    <= '0;
         exc_epc_o     <= '0;
         exc_bd_o      <= 1'b0;
         badvaddr_we_o <= 1'b0;
         badvaddr_o    <= '0;
         eret_o        <= 1'b0;
         new_pc_o      <= '0;
      end else begin
         exc_valid_o   <= take & has_exc;
         eret_o        <= take & ~has_exc;
         exc_code_o    <= (take & has_exc) ? code_sel : 5'd0;
         exc_epc_o     <= (take & has_exc) ? epc_val : 32'd0;
         exc_bd_o      <= take & has_exc & stg_bd;
         badvaddr_we_o <= take & has_exc & badv_sel;
         badvaddr_o    <= (take & has_exc & badv_sel) ? badv_val : 32'd0;
         // Redirect PC is held for the whole flush window and cleared when it ends.
         if (take)
            new_pc_o <= has_exc ? EXC_VECTOR : cp0_epc_i;
         else if (state == ST_FLUSH && state_next == ST_IDLE)
            new_pc_o <= '0;
      end
   end

endmodule

// File: tb/tb_except_commit.sv
// -----------------------------------------------------------------------------
// tb_except_commit
//
// Directed scenarios followed by randomized traffic. A behavioural model works
// out the expected outputs for every cycle from the cause-priority rules and
// the flush window. A negedge compare process checks the DUT against it, and
// the directed scenarios also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_except_commit;

   localparam logic [31:0] VEC = 32'hBFC00380;
   localparam int          FC  = 2;
   localparam int          SS  = 2;
`ifdef EXCEPT_COMMIT_INT_SYNC_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic        clk;
   logic        resetn;
   logic        stall_i, flush_i, in_valid_i, delay_slot_i;
   logic [31:0] excepttype_i, pc_i, mem_addr_i;
   logic [5:0]  hw_int_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        exc_valid_o, exc_bd_o, badvaddr_we_o, eret_o, flush_o;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_epc_o, badvaddr_o, new_pc_o;
   logic [5:0]  ip_hw_o;

   except_commit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC), .SYNC_STAGES(SS)) dut (
      .clk(clk), .resetn(resetn), .stall_i(stall_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
      .delay_slot_i(delay_slot_i), .mem_addr_i(mem_addr_i), .hw_int_i(hw_int_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .exc_epc_o(exc_epc_o),
      .exc_bd_o(exc_bd_o), .badvaddr_we_o(badvaddr_we_o), .badvaddr_o(badvaddr_o),
      .eret_o(eret_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .ip_hw_o(ip_hw_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   // Causes listed from highest to lowest priority, with the ExcCode of each.
   int prio_bit  [7] = '{0, 4, 10, 12, 8, 9, 5};
   int prio_code [7] = '{0, 4, 10, 12, 8, 9, 5};

   bit          m_valid, m_bd;
   logic [31:0] m_type, m_pc, m_addr;
   int          cyc, flush_end;
   logic [31:0] w_pc;
   logic [5:0]  hist[$];
   bit          e_exc_valid, e_eret, e_bd, e_bwe, e_flush;
   logic [4:0]  e_code;
   logic [31:0] e_epc, e_badv, e_newpc;

   function automatic logic [5:0] model_ip();
      return SYNC_ON ? hist[0] : hw_int_i;
   endfunction

   task automatic m_reset();
      m_valid = 0; m_bd = 0; m_type = '0; m_pc = '0; m_addr = '0;
      flush_end = -1; w_pc = '0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back(6'd0);
      e_exc_valid = 0; e_eret = 0; e_bd = 0; e_bwe = 0; e_flush = 0;
      e_code = '0; e_epc = '0; e_badv = '0; e_newpc = '0;
   endtask

   task automatic m_step();
      logic [31:0] causes;
      logic [5:0]  ip;
      bit          in_fl, found, take, pend;
      int          code;
      in_fl  = (cyc <= flush_end);
      ip     = model_ip();
      pend   = cp0_status_i[0] && !cp0_status_i[1] &&
               (({ip, cp0_cause_i[9:8]} & cp0_status_i[15:8]) != 8'd0);
      causes = m_type;
      if (pend) causes[0] = 1'b1;
      found = 0; code = 0;
      for (int i = 0; i < 7; i++)
         if (!found && causes[prio_bit[i]]) begin found = 1; code = prio_code[i]; end
      take = !in_fl && m_valid && !stall_i && !flush_i && (found || m_type[31]);
      e_exc_valid = take && found;
      e_eret      = take && !found;
      e_code      = e_exc_valid ? code[4:0] : 5'd0;
      e_epc       = e_exc_valid ? (m_bd ? m_pc - 32'd4 : m_pc) : 32'd0;
      e_bd        = e_exc_valid && m_bd;
      e_bwe       = e_exc_valid && (code == 4 || code == 5);
      e_badv      = e_bwe ? ((m_pc[1:0] != 2'b00) ? m_pc : m_addr) : 32'd0;
      if (take) begin
         flush_end = cyc + FC;
         w_pc      = found ? VEC : cp0_epc_i;
      end
      if (flush_i || in_fl) m_valid = 0;
      else if (!stall_i) begin
         m_valid = in_valid_i; m_type = excepttype_i; m_pc = pc_i;
         m_bd = delay_slot_i; m_addr = mem_addr_i;
      end
      hist.push_back(hw_int_i);
      void'(hist.pop_front());
      cyc++;
      e_flush = (cyc <= flush_end);
      e_newpc = e_flush ? w_pc : 32'd0;
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_reset();
      else         m_step();
   end

   // ------------------------------------------------------------ compare process
   always @(negedge clk) begin
      chk("exc_valid_o",   exc_valid_o,   e_exc_valid);
      chk("eret_o",        eret_o,        e_eret);
      chk("exc_code_o",    exc_code_o,    e_code);
      chk("exc_epc_o",     exc_epc_o,     e_epc);
      chk("exc_bd_o",      exc_bd_o,      e_bd);
      chk("badvaddr_we_o", badvaddr_we_o, e_bwe);
      chk("badvaddr_o",    badvaddr_o,    e_badv);
      chk("flush_o",       flush_o,       e_flush);
      chk("new_pc_o",      new_pc_o,      e_newpc);
      chk("ip_hw_o",       ip_hw_o,       model_ip());
   end

   // ------------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] et, input logic [31:0] pc, input logic bd,
                        input logic [31:0] addr);
      in_valid_i = 1; excepttype_i = et; pc_i = pc; delay_slot_i = bd;
      mem_addr_i = addr; stall_i = 0; flush_i = 0;
   endtask

   // Issue one instruction and advance to the cycle its commit would be visible.
   task automatic run_one(input logic [31:0] et, input logic [31:0] pc, input logic bd,
                          input logic [31:0] addr);
      issue(et, pc, bd, addr);
      tick();
      in_valid_i = 0;
      tick();
      $display("txn et=%h pc=%h bd=%0d -> valid=%0d eret=%0d code=%0d epc=%h newpc=%h",
               et, pc, bd, exc_valid_o, eret_o, exc_code_o, exc_epc_o, new_pc_o);
   endtask

   int pulses;

   initial begin
      cyc = 0;
      m_reset();
      resetn = 0; stall_i = 0; flush_i = 0; in_valid_i = 0; delay_slot_i = 0;
      excepttype_i = '0; pc_i = '0; mem_addr_i = '0; hw_int_i = '0;
      cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
      repeat (3) tick();
      chk("reset_exc_valid", exc_valid_o, 0);
      chk("reset_flush", flush_o, 0);
      chk("reset_new_pc", new_pc_o, 0);
      resetn = 1;
      tick();

      // Sys, not in a delay slot
      cp0_status_i = 32'h0000FF01;
      run_one(32'h0000_0100, 32'h80001000, 1'b0, 32'h0);
      chk("sys_valid", exc_valid_o, 1);
      chk("sys_code", exc_code_o, 8);
      chk("sys_epc", exc_epc_o, 32'h80001000);
      chk("sys_bd", exc_bd_o, 0);
      chk("sys_new_pc", new_pc_o, 32'hBFC00380);
      chk("sys_flush1", flush_o, 1);
      tick();
      chk("sys_flush2", flush_o, 1);
      chk("sys_pulse_end", exc_valid_o, 0);
      chk("sys_new_pc_hold", new_pc_o, 32'hBFC00380);
      tick();
      chk("sys_flush_end", flush_o, 0);
      repeat (2) tick();

      // Sys in a delay slot
      run_one(32'h0000_0100, 32'h80001000, 1'b1, 32'h0);
      chk("bd_epc", exc_epc_o, 32'h80000FFC);
      chk("bd_flag", exc_bd_o, 1);
      repeat (4) tick();

      // Ri and Ov together
      run_one(32'h0000_1400, 32'h80001000, 1'b0, 32'h0);
      chk("ri_ov_code", exc_code_o, 10);
      repeat (4) tick();

      // AdEL on a misaligned PC
      run_one(32'h0000_0010, 32'h80001002, 1'b0, 32'h12345678);
      chk("adel_code", exc_code_o, 4);
      chk("adel_we", badvaddr_we_o, 1);
      chk("adel_badv", badvaddr_o, 32'h80001002);
      repeat (4) tick();

      // Hardware interrupt against a Sys instruction
      cp0_status_i = 32'h00000401;
      hw_int_i = 6'b000001;
      repeat (3) tick();
      chk("int_ip", ip_hw_o[0], 1);
      run_one(32'h0000_0100, 32'h80003000, 1'b0, 32'h0);
      chk("int_code", exc_code_o, 0);
      chk("int_valid", exc_valid_o, 1);
      repeat (4) tick();
      cp0_status_i = 32'h00000403;
      run_one(32'h0000_0100, 32'h80003000, 1'b0, 32'h0);
      chk("exl_code", exc_code_o, 8);
      hw_int_i = '0;
      cp0_status_i = 32'h0000FF01;
      repeat (6) tick();

      // ERET
      cp0_epc_i = 32'h80002000;
      run_one(32'h8000_0000, 32'h80004000, 1'b0, 32'h0);
      chk("eret_pulse", eret_o, 1);
      chk("eret_no_exc", exc_valid_o, 0);
      chk("eret_new_pc", new_pc_o, 32'h80002000);
      repeat (4) tick();

      // Two faulting instructions back to back
      issue(32'h0000_0100, 32'h80005000, 1'b0, 32'h0);
      tick();
      pc_i = 32'h80005004;
      tick();
      pulses = int'(exc_valid_o);
      in_valid_i = 0;
      repeat (6) begin
         tick();
         pulses += int'(exc_valid_o);
      end
      chk("b2b_pulses", pulses, 1);

      // External flush squashes a Sys in the stage
      issue(32'h0000_0100, 32'h80006000, 1'b0, 32'h0);
      tick();
      in_valid_i = 0; flush_i = 1;
      tick();
      chk("flush_no_commit", exc_valid_o, 0);
      chk("flush_no_window", flush_o, 0);
      flush_i = 0;
      tick();
      chk("flush_squashed", exc_valid_o, 0);
      repeat (2) tick();

      // Stall holds the instruction; commit follows once stall drops
      issue(32'h0000_0100, 32'h80007000, 1'b0, 32'h0);
      tick();
      in_valid_i = 0; stall_i = 1;
      tick();
      chk("stall_hold1", exc_valid_o, 0);
      tick();
      chk("stall_hold2", exc_valid_o, 0);
      stall_i = 0;
      tick();
      chk("stall_release", exc_valid_o, 1);
      chk("stall_code", exc_code_o, 8);
      repeat (4) tick();

      // Reset pulled low in the middle of the flush window
      run_one(32'h0000_0100, 32'h80008000, 1'b0, 32'h0);
      chk("rst_pre_flush", flush_o, 1);
      resetn = 0;
      #1;
      chk("rst_valid", exc_valid_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_new_pc", new_pc_o, 0);
      chk("rst_epc", exc_epc_o, 0);
      tick();
      resetn = 1;
      repeat (4) tick();
      chk("rst_no_commit", exc_valid_o, 0);
      chk("rst_no_flush", flush_o, 0);

      // Randomized traffic
      repeat (3000) begin
         tick();
         in_valid_i   = 1'($urandom_range(0, 1));
         excepttype_i = '0;
         if ($urandom % 40 == 0) excepttype_i[0] = 1'b1;
         for (int b = 0; b < 7; b++)
            if ($urandom % 10 == 0) excepttype_i[prio_bit[b]] = 1'b1;
         if ($urandom % 10 == 0) excepttype_i[31] = 1'b1;
         pc_i = $urandom;
         if ($urandom % 4 != 0) pc_i[1:0] = 2'b00;
         delay_slot_i = 1'($urandom_range(0, 1));
         mem_addr_i   = $urandom;
         stall_i      = ($urandom % 5 == 0);
         flush_i      = ($urandom % 10 == 0);
         if ($urandom % 20 == 0) hw_int_i = 6'($urandom);
         case ($urandom % 5)
            0: cp0_status_i = 32'h0000FF01;
            1: cp0_status_i = 32'h00000401;
            2: cp0_status_i = 32'h00000403;
            3: cp0_status_i = 32'h00000000;
            default: cp0_status_i = $urandom;
         endcase
         cp0_cause_i = '0;
         cp0_cause_i[9:8] = 2'($urandom);
         cp0_epc_i = $urandom;
      end

      in_valid_i = 0; stall_i = 0; flush_i = 0;
      repeat (5) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
